// File: rtl/qam_frame_ctrl.sv
// Frame sequencer for the 16-QAM chain: fixed F/0 preamble, paced payload from a
// one-entry hold register, then a silent guard, with an alignment pulse on symbol one.
module qam_frame_ctrl #(
  parameter int SYM_DIV   = 8,
  parameter int PRE_LEN   = 4,
  parameter int GUARD_LEN = 2,
  parameter int LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [3:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [3:0]       sym_out,
  output logic             sym_stb,
  output logic             m_align,
  output logic             busy,
  output logic             underrun,
  output logic             done
);

  localparam int DIV_W  = $clog2(SYM_DIV);
  localparam int PG_MAX = (PRE_LEN > GUARD_LEN) ? PRE_LEN : GUARD_LEN;
  localparam int PG_W   = $clog2(PG_MAX + 1);
  localparam int CNT_W  = (PG_W > LEN_W) ? PG_W : LEN_W;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SYM_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(SYM_DIV - 2);
  localparam logic [CNT_W-1:0] PRE_CNT    = CNT_W'(PRE_LEN);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    PAY   = 2'd2,
    GUARD = 2'd3
  } state_t;

  state_t state, state_d;

  logic [DIV_W-1:0] div_cnt, div_d;
  logic [CNT_W-1:0] sym_cnt, sym_cnt_d;
  logic [LEN_W-1:0] fetch_cnt, fetch_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [3:0]       hold_q, hold_d;
  logic             hold_full, hold_full_d;
  logic [3:0]       sym_out_d;
  logic             sym_stb_d, m_align_d, underrun_d, done_d;

  logic tick;
  logic sym_load;
  logic accept;

  // Outputs are registered, so the symbol is committed one cycle ahead of the
  // tick; the strobe then lands exactly in the tick cycle.
  assign tick     = (div_cnt == DIV_LAST);
  assign sym_load = (div_cnt == DIV_LOAD);

  assign busy       = (state != IDLE);
  assign data_ready = ((state == PRE) || (state == PAY)) && !hold_full && (fetch_cnt < len_q);
  assign accept     = data_valid && data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    div_d       = div_cnt;
    sym_cnt_d   = sym_cnt;
    fetch_d     = fetch_cnt;
    len_d       = len_q;
    hold_d      = hold_q;
    hold_full_d = hold_full;
    sym_out_d   = sym_out;
    sym_stb_d   = 1'b0;
    m_align_d   = 1'b0;
    underrun_d  = 1'b0;
    done_d      = 1'b0;

    if (state != IDLE) begin
      div_d = tick ? '0 : div_cnt + 1'b1;
    end

    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
      fetch_d     = fetch_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          state_d     = PRE;
          len_d       = frame_len;
          div_d       = '0;
          sym_cnt_d   = '0;
          fetch_d     = '0;
          hold_full_d = 1'b0;
        end
      end

      PRE: begin
        if (sym_load) begin
          sym_out_d = sym_cnt[0] ? 4'h0 : 4'hF;
          sym_stb_d = 1'b1;
          m_align_d = (sym_cnt == '0);
          sym_cnt_d = sym_cnt + 1'b1;
        end
        if (tick && (sym_cnt == PRE_CNT)) begin
          state_d   = PAY;
          sym_cnt_d = '0;
        end
      end

      PAY: begin
        // A missing symbol is replaced by zero and dropped, never sent late.
        if (sym_load) begin
          sym_stb_d = 1'b1;
          sym_cnt_d = sym_cnt + 1'b1;
          if (hold_full) begin
            sym_out_d   = hold_q;
            hold_full_d = 1'b0;
          end else begin
            sym_out_d  = 4'h0;
            underrun_d = 1'b1;
          end
        end
        if (tick && (sym_cnt == CNT_W'(len_q))) begin
          state_d   = GUARD;
          sym_cnt_d = '0;
          sym_out_d = 4'h0;
        end
      end

      GUARD: begin
        if (tick) begin
          sym_cnt_d = sym_cnt + 1'b1;
        end
        // Leave one cycle early so done coincides with the frame's final period edge.
        if (sym_load && (sym_cnt == GUARD_LAST)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      sym_cnt   <= '0;
      fetch_cnt <= '0;
      len_q     <= '0;
      hold_q    <= 4'h0;
      hold_full <= 1'b0;
      sym_out   <= 4'h0;
      sym_stb   <= 1'b0;
      m_align   <= 1'b0;
      underrun  <= 1'b0;
      done      <= 1'b0;
    end else begin
      div_cnt   <= div_d;
      sym_cnt   <= sym_cnt_d;
      fetch_cnt <= fetch_d;
      len_q     <= len_d;
      hold_q    <= hold_d;
      hold_full <= hold_full_d;
      sym_out   <= sym_out_d;
      sym_stb   <= sym_stb_d;
      m_align   <= m_align_d;
      underrun  <= underrun_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_qam_frame_ctrl.sv
// Self-checking bench for qam_frame_ctrl: table of frame scenarios checked against
// a timing model, plus hand sequences for reset, ignored starts and back-to-back frames.
module tb_qam_frame_ctrl;

  localparam int SYM_DIV   = 8;
  localparam int PRE_LEN   = 4;
  localparam int GUARD_LEN = 2;
  localparam int LEN_W     = 8;
  localparam int BUDGET    = 300;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic [3:0]       data_in;
  logic             data_valid;
  logic             data_ready;
  logic [3:0]       sym_out;
  logic             sym_stb;
  logic             m_align;
  logic             busy;
  logic             underrun;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qam_frame_ctrl #(
    .SYM_DIV  (SYM_DIV),
    .PRE_LEN  (PRE_LEN),
    .GUARD_LEN(GUARD_LEN),
    .LEN_W    (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .sym_out   (sym_out),
    .sym_stb   (sym_stb),
    .m_align   (m_align),
    .busy      (busy),
    .underrun  (underrun),
    .done      (done)
  );

  typedef struct {
    int    len;
    int    supply;
    int    mid_start;
    string name;
  } frame_vec_t;

  frame_vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sym_of(input int j);
    return 4'((j * 3 + 5) % 16);
  endfunction

  function automatic logic [3:0] exp_val(input int i, input int supply);
    int j;
    if (i < PRE_LEN) return (i % 2 == 0) ? 4'hF : 4'h0;
    j = i - PRE_LEN;
    return (j < supply) ? sym_of(j) : 4'h0;
  endfunction

  // Starts a frame in the current cycle (offset 0) and runs until done or the budget.
  task automatic applyStimulus(input int len, input int supply, input int mid_start, input string tag);
    int         strobe_k[$];
    logic [3:0] strobe_v[$];
    int         align_k[$];
    int         under_k[$];
    int         done_k = -1;
    int         hs = 0;
    int         consumed = 0;
    int         max_out = 0;
    int         ready_bad = 0;
    int         hold_bad = 0;
    int         busy_at_done = 1;
    int         n_sym = PRE_LEN + len;
    int         n_under = (len > supply) ? len - supply : 0;
    int         n_hs = (supply < len) ? supply : len;
    logic [3:0] prev_sym;

    prev_sym = sym_out;
    for (int k = 0; k <= BUDGET && done_k < 0; k++) begin
      if (k > 0) cycle();
      start = (k == 0) || (mid_start > 0 && k == mid_start);
      if (k == 0) frame_len = LEN_W'(len);
      else if (k == mid_start) frame_len = LEN_W'(len + 2);
      else frame_len = 8'hFF;
      data_valid = (hs < supply);
      data_in    = sym_of(hs);

      if (sym_stb) begin
        strobe_k.push_back(k);
        strobe_v.push_back(sym_out);
        if (strobe_k.size() > PRE_LEN && !underrun) consumed++;
      end else if (sym_out !== prev_sym && sym_out !== 4'h0) begin
        hold_bad++;
      end
      prev_sym = sym_out;
      if (m_align) align_k.push_back(k);
      if (underrun) under_k.push_back(k);
      if (done) begin
        done_k = k;
        busy_at_done = busy;
      end
      if (hs - consumed > max_out) max_out = hs - consumed;
      if (hs - consumed < 0) hold_bad++;
      if (data_ready && (!busy || k > n_sym * SYM_DIV)) ready_bad++;
      if (data_valid && data_ready) hs++;
    end
    start = 1'b0;
    data_valid = 1'b0;

    checkOutput({tag, " done_offset"}, done_k, (n_sym + GUARD_LEN) * SYM_DIV);
    checkOutput({tag, " busy_at_done"}, busy_at_done, 0);
    checkOutput({tag, " strobe_count"}, strobe_k.size(), n_sym);
    for (int i = 0; i < strobe_k.size() && i < n_sym; i++) begin
      checkOutput($sformatf("%s strobe%0d_time", tag, i), strobe_k[i], (i + 1) * SYM_DIV);
      checkOutput($sformatf("%s strobe%0d_value", tag, i), strobe_v[i], exp_val(i, supply));
    end
    checkOutput({tag, " align_count"}, align_k.size(), 1);
    if (align_k.size() > 0) checkOutput({tag, " align_time"}, align_k[0], SYM_DIV);
    checkOutput({tag, " underrun_count"}, under_k.size(), n_under);
    for (int j = 0; j < under_k.size() && j < n_under; j++) begin
      checkOutput($sformatf("%s underrun%0d_time", tag, j), under_k[j],
                  (PRE_LEN + supply + j + 1) * SYM_DIV);
    end
    checkOutput({tag, " handshakes"}, hs, n_hs);
    checkOutput({tag, " max_outstanding"}, max_out, (supply > 0) ? 1 : 0);
    checkOutput({tag, " ready_outside_frame"}, ready_bad, 0);
    checkOutput({tag, " sym_out_hold"}, hold_bad, 0);
  endtask

  initial begin
    int busy_seen;
    int done_seen;

    vecs[0] = '{len: 3, supply: 3, mid_start: 0,  name: "nominal"};
    vecs[1] = '{len: 2, supply: 1, mid_start: 0,  name: "underrun"};
    vecs[2] = '{len: 1, supply: 1, mid_start: 0,  name: "len1"};
    vecs[3] = '{len: 3, supply: 3, mid_start: 20, name: "mid_start"};
    vecs[4] = '{len: 4, supply: 0, mid_start: 0,  name: "all_underrun"};
    vecs[5] = '{len: 5, supply: 9, mid_start: 0,  name: "backpressure"};

    rst = 1'b1;
    start = 1'b0;
    frame_len = '0;
    data_in = 4'h0;
    data_valid = 1'b0;
    cycle();
    cycle();
    checkOutput("reset sym_out", sym_out, 0);
    checkOutput("reset sym_stb", sym_stb, 0);
    checkOutput("reset m_align", m_align, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset data_ready", data_ready, 0);
    checkOutput("reset underrun", underrun, 0);
    checkOutput("reset done", done, 0);
    rst = 1'b0;
    cycle();

    // Zero-length request must be ignored
    start = 1'b1;
    frame_len = '0;
    cycle();
    start = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy || sym_stb) busy_seen++;
      cycle();
    end
    checkOutput("zero_len busy", busy_seen, 0);

    foreach (vecs[v]) begin
      $display("[TB] running %s", vecs[v].name);
      applyStimulus(vecs[v].len, vecs[v].supply, vecs[v].mid_start, vecs[v].name);
      cycle();
      cycle();
    end

    // Back-to-back: second start in the cycle after done
    applyStimulus(2, 2, 0, "b2b_first");
    cycle();
    applyStimulus(2, 2, 0, "b2b_second");
    cycle();

    // Reset during PAY, then a clean frame
    start = 1'b1;
    frame_len = 8'd3;
    data_valid = 1'b1;
    data_in = 4'h9;
    for (int k = 1; k <= 44; k++) begin
      cycle();
      start = 1'b0;
    end
    checkOutput("pre_reset busy", busy, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkOutput("midrst sym_out", sym_out, 0);
    checkOutput("midrst sym_stb", sym_stb, 0);
    checkOutput("midrst m_align", m_align, 0);
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst data_ready", data_ready, 0);
    checkOutput("midrst underrun", underrun, 0);
    checkOutput("midrst done", done, 0);
    data_valid = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    checkOutput("midrst no_done", done_seen, 0);
    checkOutput("midrst stays_idle", busy_seen, 0);
    applyStimulus(3, 3, 0, "post_reset");
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qam_frame_ctrl.md
# qam_frame_ctrl

Frame sequencer for the 16-QAM modulation chain. Takes a frame request and a payload stream of 4-bit symbols, and emits a paced symbol stream with a symbol strobe to the modulator. Each frame is a fixed preamble, then the payload, then a silent guard interval. It also generates the `m_align` frame-alignment pulse that the I/Q mapper and the downstream `SigI`/`SigQ`/`Siga`/`Sigb` stages use to lock onto the first preamble symbol.

## Interface
- `SYM_DIV`, 8, clocks per symbol period (≥2)
- `PRE_LEN`, 4, preamble length in symbols (≥1)
- `GUARD_LEN`, 2, guard length in symbol periods (≥1)
- `LEN_W`, 8, width of `frame_len`

- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  frame request, sampled every cycle
- `frame_len`  in  LEN_W  payload symbol count, latched on accepted `start`
- `data_in`  in  4  payload symbol {I1,I0,Q1,Q0}
- `data_valid`  in  1  `data_in` valid
- `data_ready`  out  1  controller accepts `data_in` this cycle
- `sym_out`  out  4  symbol to modulator, registered
- `sym_stb`  out  1  one-cycle strobe: `sym_out` is a new symbol
- `m_align`  out  1  one-cycle pulse with the first preamble `sym_stb`
- `busy`  out  1  frame in progress
- `underrun`  out  1  one-cycle pulse: payload symbol missing at strobe
- `done`  out  1  one-cycle pulse at end of guard

## Operation
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- States: IDLE, PRE, PAY, GUARD.
- IDLE → PRE when `start`=1 and `frame_len`≠0. On this transition:
  - latch `frame_len`
  - clear `div_cnt`, `sym_cnt` and `fetch_cnt`
- In IDLE, `start` with `frame_len`=0 is ignored. `start` in any non-IDLE state is ignored.
- `div_cnt` counts 0..SYM_DIV-1 and wraps. It runs only outside IDLE. The symbol tick is `div_cnt`=SYM_DIV-1.
- PRE:
  - on each tick, `sym_out` takes the preamble pattern F,0,F,0…, starting with 4'hF, and `sym_stb` pulses
  - `m_align` pulses on the first tick only
  - after PRE_LEN ticks → PAY
- PAY:
  - on each tick, if the hold register is full, `sym_out` ← hold register, `sym_stb` pulses and the register empties
  - if the hold register is empty, `sym_out` ← 4'h0, `sym_stb` still pulses, and `underrun` pulses; the missing symbol is not sent later
  - after `frame_len` ticks → GUARD
- Fetch path:
  - the hold register is 1 entry deep
  - `data_ready` = (state∈{PRE,PAY}) & hold empty & (`fetch_cnt` < latched length); it is combinational from registered state only
  - an accepted transfer (`data_valid`&`data_ready`) fills the hold register and increments `fetch_cnt`
  - prefetch during PRE is therefore allowed
- GUARD:
  - `sym_stb` stays 0 and `sym_out` stays 4'h0
  - after GUARD_LEN ticks → IDLE, with `done` pulsing in the cycle the state returns to IDLE
- `busy` = state≠IDLE.
- Reset mid-frame:
  - all outputs return to their reset values next cycle
  - the hold register is discarded
  - no `done` pulse is generated

## Timing
- Reset values: `sym_out`=0, `sym_stb`=0, `m_align`=0, `busy`=0, `data_ready`=0, `underrun`=0, `done`=0, state IDLE.
- `start` sampled in cycle t → `busy`=1 and `div_cnt`=0 in cycle t+1.
- The first `sym_stb` (with `m_align`) occurs in cycle t+SYM_DIV.
- Strobes are spaced exactly SYM_DIV cycles apart through PRE and PAY.
- `sym_out` changes only in strobe cycles (or to 0 on entering GUARD) and holds between them.
- The first payload strobe occurs SYM_DIV cycles after the last preamble strobe.
- `done` occurs (GUARD_LEN)·SYM_DIV cycles after the last payload strobe. A new `start` is accepted in the cycle after `done`.
- Total frame duration from `start` to `done` is (PRE_LEN+len+GUARD_LEN)·SYM_DIV cycles.
- There is no same-cycle fill and drain of the hold register, because `data_ready` is low while the register is full.

## Test plan
- Nominal frame: `frame_len`=3, `data_valid` held high with data A,B,C → `sym_stb` at t+8,16,24,32 carrying F,0,F,0 (`m_align` only at t+8). Then A,B,C at t+40,48,56, no `underrun`, `done` at t+72.
- Underrun: `frame_len`=2, first symbol supplied, `data_valid` low afterwards → second payload strobe gives `sym_out`=0 with a one-cycle `underrun`; frame length is unchanged.
- Ignored requests:
  - `start` with `frame_len`=0 → `busy` stays 0
  - `start` pulsed mid-frame → no restart, timing unchanged
- Backpressure: `data_valid` constantly 1 → exactly `frame_len` handshakes per frame, never more than one outstanding, and `data_ready`=0 in GUARD and IDLE.
- Reset mid-PAY: assert `rst` for 1 cycle → all outputs 0 the next cycle, no `done`. A following `start` produces a full frame with `m_align` at +SYM_DIV.
- Back-to-back frames: `start` in the cycle after `done` → second `m_align` exactly SYM_DIV cycles later.
